data_mem_responder: RTL and testbench

- Memory-side responder for the pipeline core's data interface.
- Samples the core's read/write requests (`mem_ren`, `mem_wen`, `mem_addr`, `mem_dout`) and serves them from an internal word-addressed RAM.
- Returns read data on `mem_din` and asserts `mem_stall` while an access is in flight.
- Sits between the core's MEM stage and the board-level memory map; it replaces the zero-latency behavioural data RAM so that the stall path can be exercised.

---
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// | Module   : data_mem_responder_if                                        |
// | Brief    : Core-to-data-memory request/response bundle.                 |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

interface data_mem_responder_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        addr_err;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        input  mem_din, mem_stall, addr_err
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        output mem_din, mem_stall, addr_err
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// | Module   : data_mem_responder                                           |
// | Brief    : Word-addressed data RAM serving the core's MEM stage, with   |
// |            optional wait states enabled by DATA_MEM_WAIT_EN.            |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_responder_if.slave mem_bus
);

    localparam int         c_depth    = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_cnt_load = 4'(WAIT_CYCLES - 1);

    logic [31:0] r_ram [c_depth];

`ifdef DATA_MEM_WAIT_EN
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  r_ren_l;
    logic                  r_wen_l;
    logic [31:0]           r_addr_l;
    logic [31:0]           r_wdata_l;
    logic [31:0]           r_din;
    logic                  r_err;
    logic                  w_req;
    logic                  w_latch;
    logic                  w_access;
    logic                  w_stall;
    logic                  w_fault_l;
    logic [ADDR_WIDTH-1:0] w_idx_l;

    assign w_req     = mem_bus.mem_ren | mem_bus.mem_wen;
    assign w_fault_l = (r_addr_l[1:0] != 2'b00) || (r_addr_l[31:ADDR_WIDTH+2] != '0);
    assign w_idx_l   = r_addr_l[ADDR_WIDTH+1:2];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_access    = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_req) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = c_cnt_load;
                    w_state_nxt = c_st_wait;
                    w_stall     = 1'b1;
                end
            end
            c_st_wait: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = c_st_done;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            // DONE ignores any still-held request; it is served already.
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    assign mem_bus.mem_stall = w_stall;
    assign mem_bus.mem_din   = r_din;
    assign mem_bus.addr_err  = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= 4'd0;
            r_ren_l   <= 1'b0;
            r_wen_l   <= 1'b0;
            r_addr_l  <= 32'd0;
            r_wdata_l <= 32'd0;
            r_din     <= 32'd0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_access & w_fault_l;
            if (w_latch) begin
                r_ren_l   <= mem_bus.mem_ren;
                r_wen_l   <= mem_bus.mem_wen;
                r_addr_l  <= mem_bus.mem_addr;
                r_wdata_l <= mem_bus.mem_dout;
            end
            if (w_access && r_ren_l) begin
                r_din <= w_fault_l ? 32'd0 : (r_wen_l ? r_wdata_l : r_ram[w_idx_l]);
            end
        end
    end

    // Reset forces IDLE asynchronously, so an aborted access never reaches w_access.
    always_ff @(posedge clk) begin
        if (w_access && r_wen_l && !w_fault_l) begin
            r_ram[w_idx_l] <= r_wdata_l;
        end
    end

`else
    logic                  w_fault;
    logic                  w_unused;
    logic [ADDR_WIDTH-1:0] w_idx;

    assign w_idx   = mem_bus.mem_addr[ADDR_WIDTH+1:2];
    assign w_fault = (mem_bus.mem_addr[1:0] != 2'b00) ||
                     (mem_bus.mem_addr[31:ADDR_WIDTH+2] != '0);

    assign mem_bus.mem_stall = 1'b0;
    assign mem_bus.addr_err  = (mem_bus.mem_ren | mem_bus.mem_wen) & w_fault;
    assign mem_bus.mem_din   = (!mem_bus.mem_ren || w_fault) ? 32'd0 :
                               (mem_bus.mem_wen ? mem_bus.mem_dout : r_ram[w_idx]);

    always_ff @(posedge clk) begin
        if (mem_bus.mem_wen && !w_fault) begin
            r_ram[w_idx] <= mem_bus.mem_dout;
        end
    end

    assign w_unused = ^{rst_n, c_cnt_load};
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// | Module   : tb_data_mem_responder                                        |
// | Brief    : Scoreboard bench for data_mem_responder (both build modes).  |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

    localparam int ADDR_WIDTH  = 10;
    localparam int WAIT_CYCLES = 2;
`ifdef DATA_MEM_WAIT_EN
    localparam bit c_wait_mode = 1'b1;
`else
    localparam bit c_wait_mode = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] din;
        logic        err;
        bit          chk_din;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    data_mem_responder_if bus ();

    data_mem_responder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response is the DONE cycle (stall falling) with wait states,
    // or any request cycle without them.
    bit prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        bit   resp;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            resp = c_wait_mode ? (prev_stall && !bus.mem_stall)
                               : (bus.mem_ren || bus.mem_wen);
            if (resp) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got response din=%h err=%b expected none",
                             bus.mem_din, bus.addr_err);
                end else begin
                    e = sb.pop_front();
                    if (e.chk_din) check({e.name, "_din"}, bus.mem_din, e.din);
                    check({e.name, "_err"}, {31'd0, bus.addr_err}, {31'd0, e.err});
                end
            end else begin
                check("err_idle", {31'd0, bus.addr_err}, 32'd0);
            end
            prev_stall = bus.mem_stall;
        end
    end

    task automatic access(input bit ren, input bit wen, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_din,
                          input bit exp_err, input string name, input bit mutate);
        exp_t e;
        e.name    = name;
        e.din     = exp_din;
        e.err     = exp_err;
        e.chk_din = ren || !c_wait_mode;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.mem_ren  = ren;
        bus.mem_wen  = wen;
        bus.mem_addr = addr;
        bus.mem_dout = data;
        if (c_wait_mode) begin
            for (int i = 0; i <= WAIT_CYCLES; i++) begin
                @(negedge clk);
                check({name, "_stall_hi"}, {31'd0, bus.mem_stall}, 32'd1);
                if (i < WAIT_CYCLES) begin
                    @(posedge clk);
                    #1;
                    if (mutate) begin
                        bus.mem_addr = addr + 32'd4;
                        bus.mem_dout = ~data;
                    end
                end
            end
            @(posedge clk);
            #1;
            bus.mem_ren = 1'b0;
            bus.mem_wen = 1'b0;
            @(negedge clk);
            check({name, "_stall_lo"}, {31'd0, bus.mem_stall}, 32'd0);
        end else begin
            @(negedge clk);
            check({name, "_stall_lo"}, {31'd0, bus.mem_stall}, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        bus.mem_ren = 1'b0;
        bus.mem_wen = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bus.mem_ren  = 1'b0;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = 32'd0;
        bus.mem_dout = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_stall", {31'd0, bus.mem_stall}, 32'd0);
        check("rst_din",   bus.mem_din, 32'd0);
        check("rst_err",   {31'd0, bus.addr_err}, 32'd0);

        access(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, "wr_10", 0);
        access(1, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, "rd_10", 0);
        access(0, 1, 32'h0000_0013, 32'h0BAD_F00D, 32'h0, 1, "wr_13_fault", 0);
        access(1, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, "rd_10_again", 0);
        access(1, 0, 32'h0000_1000, 32'h0,         32'h0, 1, "rd_1000_fault", 0);
        access(1, 0, 32'h0000_0011, 32'h0,         32'h0, 1, "rd_11_fault", 0);
        access(0, 1, 32'h0000_0FFC, 32'h7777_8888, 32'h0, 0, "wr_top", 0);
        access(1, 0, 32'h0000_0FFC, 32'h0,         32'h7777_8888, 0, "rd_top", 0);
        access(0, 1, 32'h0000_0008, 32'hA5A5_A5A5, 32'h0, 0, "wr_08", 0);
        access(1, 0, 32'h0000_0008, 32'h0,         32'hA5A5_A5A5, 0, "rd_08", 0);

        if (c_wait_mode) begin
            access(1, 1, 32'h0000_0020, 32'h1234_5678, 32'h1234_5678, 0, "rw_20", 0);
            access(1, 0, 32'h0000_0020, 32'h0,         32'h1234_5678, 0, "rd_20", 0);
            access(0, 1, 32'h0000_0034, 32'h3434_3434, 32'h0, 0, "wr_34", 0);
            access(0, 1, 32'h0000_0030, 32'h3030_3030, 32'h0, 0, "wr_30_mut", 1);
            access(1, 0, 32'h0000_0030, 32'h0,         32'h3030_3030, 0, "rd_30", 0);
            access(1, 0, 32'h0000_0034, 32'h0,         32'h3434_3434, 0, "rd_34", 0);
            access(0, 1, 32'h0000_0040, 32'h1111_2222, 32'h0, 0, "wr_40", 0);
            access(1, 0, 32'h0000_0040, 32'h0,         32'h1111_2222, 0, "rd_40", 0);

            // Start a write to 0x40, then reset it away in its WAIT phase.
            @(posedge clk);
            #1;
            bus.mem_wen  = 1'b1;
            bus.mem_addr = 32'h0000_0040;
            bus.mem_dout = 32'hCAFE_F00D;
            @(negedge clk);
            check("abort_stall_hi", {31'd0, bus.mem_stall}, 32'd1);
            @(posedge clk);
            #1;
            rst_n       = 1'b0;
            bus.mem_wen = 1'b0;
            #1;
            check("abort_stall", {31'd0, bus.mem_stall}, 32'd0);
            check("abort_din",   bus.mem_din, 32'd0);
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            access(1, 0, 32'h0000_0040, 32'h0, 32'h1111_2222, 0, "rd_40_post_abort", 0);
        end

        idle(1);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        access(1, 0, 32'h0000_0008, 32'h0, 32'hA5A5_A5A5, 0, "rd_08_post_rst", 0);
        idle(4);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
